// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry record for the instruction-fetch front end.
package fetch_pkg;

  localparam int INST_INC = 4;
  localparam int ALIGN_W  = 2;
  localparam int DEF_XLEN = 64;
  localparam int DEF_ILEN = 32;

  // Default-width {inst, pc} record; fetch_unit builds its own from its parameters.
  typedef struct packed {
    logic [DEF_ILEN-1:0] inst;
    logic [DEF_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO with push, pop and flush; flush wins over both.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Decoupled in-order instruction fetch with credit-limited issue, redirect squash and a {inst, pc} queue.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue is presented in the same cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter int               ILEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic             out_req_valid,
  input  logic             in_req_ready,
  output logic [XLEN-1:0]  out_req_addr,
  input  logic             in_rsp_valid,
  input  logic [ILEN-1:0]  in_rsp_data,
  output logic             out_inst_valid,
  input  logic             in_inst_ready,
  output logic [ILEN-1:0]  out_inst,
  output logic [XLEN-1:0]  out_inst_pc,
  input  logic             in_redirect,
  input  logic [XLEN-1:0]  in_redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  entry_t          hold_q, hold_d;

  entry_t          q_head, rsp_entry, show;
  logic [CW-1:0]   q_count;
  logic            q_empty, q_full, q_push, q_pop;
  logic            rsp_keep, want_push, inst_valid, req_valid, req_fire;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc    = in_redirect_pc & ~XLEN'((1 << ALIGN_W) - 1);
  // Queued plus in-flight (including to-be-discarded) responses bound the queue occupancy.
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding_q};
  assign req_valid   = !Rst && !in_redirect && (credit_used < (CW+1)'(DEPTH));
  assign req_fire    = req_valid && in_req_ready;

  assign rsp_keep    = in_rsp_valid && !in_redirect && (discard_q == '0);
  assign rsp_entry   = '{inst: in_rsp_data, pc: rsp_pc_q};

`ifdef FETCH_BYPASS_EN
  assign inst_valid  = !Rst && !in_redirect && (!q_empty || rsp_keep);
  assign show        = q_empty ? rsp_entry : q_head;
  assign want_push   = rsp_keep && !(q_empty && in_inst_ready);
`else
  assign inst_valid  = !Rst && !in_redirect && !q_empty;
  assign show        = q_head;
  assign want_push   = rsp_keep;
`endif

  assign q_pop       = inst_valid && in_inst_ready && !q_empty;
  assign q_push      = want_push && (!q_full || q_pop);

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (q_push),
    .wdata (rsp_entry),
    .pop   (q_pop),
    .flush (in_redirect),
    .rdata (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(in_rsp_valid);
    hold_d        = inst_valid ? show : hold_q;
    if (in_redirect) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      // A response landing this cycle is already gone; everything else in flight is stale.
      discard_d  = outstanding_q - CW'(in_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INST_INC);
      if (in_rsp_valid) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 rsp_pc_d  = rsp_pc_q + XLEN'(INST_INC);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      hold_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      hold_q        <= hold_d;
    end
  end

  assign out_req_valid  = req_valid;
  assign out_req_addr   = fetch_pc_q;
  assign out_inst_valid = inst_valid;
  assign out_inst       = inst_valid ? show.inst : hold_q.inst;
  assign out_inst_pc    = inst_valid ? show.pc   : hold_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a stream-level fetch model.
module tb_fetch_unit;

  localparam int          XLEN  = 64;
  localparam int          ILEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h1000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            Clk, Rst;
  logic            out_req_valid, in_req_ready;
  logic [XLEN-1:0] out_req_addr;
  logic            in_rsp_valid;
  logic [ILEN-1:0] in_rsp_data;
  logic            out_inst_valid, in_inst_ready;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_inst_pc;
  logic            in_redirect;
  logic [XLEN-1:0] in_redirect_pc;

  fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .Clk(Clk), .Rst(Rst),
    .out_req_valid(out_req_valid), .in_req_ready(in_req_ready), .out_req_addr(out_req_addr),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data),
    .out_inst_valid(out_inst_valid), .in_inst_ready(in_inst_ready),
    .out_inst(out_inst), .out_inst_pc(out_inst_pc),
    .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: in-order in-flight requests; stale ones were issued before a redirect.
  typedef struct {
    logic [63:0] addr;
    int          rdy;
    bit          stale;
  } mreq_t;
  mreq_t mq[$];

  int          errors = 0, checks = 0, cyc = 0;
  int          lat_lo = 1, lat_hi = 1, rsp_pct = 100;
  int          mcount;          // delivered, unconsumed live instructions
  logic [63:0] exp_pc, exp_req, last_pc;
  logic [31:0] last_inst;
  logic        s_req_valid, s_inst_valid;
  logic [63:0] s_req_addr, s_inst_pc;
  int          nreq;
  logic [63:0] last_fire_addr, first_pc;
  bit          track_first;

  function automatic logic [31:0] mem_data(input logic [63:0] pc);
    return 32'h00500093 ^ pc[31:0] ^ 32'h0000_1000 ^ pc[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcount    = 0;
    exp_pc    = RPC;
    exp_req   = RPC;
    last_pc   = '0;
    last_inst = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    in_req_ready = 0; in_rsp_valid = 0; in_rsp_data = '0;
    in_inst_ready = 0; in_redirect = 0; in_redirect_pc = '0;
    #1;
    chk("rst_req_valid",  out_req_valid,  0);
    chk("rst_inst_valid", out_inst_valid, 0);
    chk("rst_req_addr",   out_req_addr,   RPC);
    chk("rst_inst",       out_inst,       0);
    chk("rst_inst_pc",    out_inst_pc,    0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit redir, input logic [63:0] rpc, input bit iready, input bit rready);
    bit          rsp, live, exp_rv, exp_iv, pop;
    logic [63:0] raddr, tgt;
    mreq_t       h;
    @(negedge Clk);
    rsp   = (mq.size() > 0) && (mq[0].rdy <= cyc) && ($urandom_range(0, 99) < rsp_pct);
    live  = rsp && !mq[0].stale;
    raddr = rsp ? mq[0].addr : 64'h0;
    in_redirect    = redir;
    in_redirect_pc = rpc;
    in_inst_ready  = iready;
    in_req_ready   = rready;
    in_rsp_valid   = rsp;
    in_rsp_data    = rsp ? mem_data(raddr) : $urandom;
    #1;
    exp_rv = !redir && ((mq.size() + mcount) < DEPTH);
    exp_iv = !redir && (mcount > 0 || (BYP && live));
    s_req_valid = out_req_valid; s_req_addr = out_req_addr;
    s_inst_valid = out_inst_valid; s_inst_pc = out_inst_pc;
    chk("req_valid",  out_req_valid,  exp_rv);
    chk("req_addr",   out_req_addr,   exp_req);
    chk("inst_valid", out_inst_valid, exp_iv);
    if (exp_iv) begin
      chk("inst_pc", out_inst_pc, exp_pc);
      chk("inst",    out_inst,    mem_data(exp_pc));
    end else begin
      chk("hold_pc",   out_inst_pc, last_pc);
      chk("hold_inst", out_inst,    last_inst);
    end
    if (out_req_valid && rready) begin
      nreq++;
      last_fire_addr = out_req_addr;
    end
    // Advance the model to the state after this clock edge.
    if (exp_iv) begin
      last_pc   = exp_pc;
      last_inst = mem_data(exp_pc);
    end
    if (redir) begin
      if (rsp) h = mq.pop_front();
      foreach (mq[i]) mq[i].stale = 1'b1;
      tgt     = {rpc[63:2], 2'b00};
      exp_pc  = tgt;
      exp_req = tgt;
      mcount  = 0;
    end else begin
      pop = exp_iv && iready;
      if (pop && track_first) begin
        first_pc    = exp_pc;
        track_first = 1'b0;
      end
      if (rsp) h = mq.pop_front();
      mcount = mcount + (live ? 1 : 0) - (pop ? 1 : 0);
      if (pop) exp_pc = exp_pc + 64'd4;
      if (exp_rv && rready) begin
        mq.push_back('{addr: exp_req, rdy: cyc + $urandom_range(lat_lo, lat_hi), stale: 1'b0});
        exp_req = exp_req + 64'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    Rst = 1'b1;
    model_reset();
    nreq = 0; track_first = 0; first_pc = '0; last_fire_addr = '0;

    // Streaming from reset, 1-cycle memory, consumer always ready.
    do_reset();
    lat_lo = 1; lat_hi = 1; rsp_pct = 100;
    step(0, 0, 1, 1); chk("t1_addr0", s_req_addr, 64'h1000);
    step(0, 0, 1, 1); chk("t1_addr1", s_req_addr, 64'h1004);
    step(0, 0, 1, 1); chk("t1_addr2", s_req_addr, 64'h1008);
    repeat (6) step(0, 0, 1, 1);

    // Credit limit: consumer stalled, latency 3.
    do_reset();
    lat_lo = 3; lat_hi = 3; nreq = 0;
    repeat (10) step(0, 0, 0, 1);
    chk("t2_nreq", nreq, 4);
    chk("t2_stall", s_req_valid, 0);
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("t2_nreq_after_pop", nreq, 5);
    chk("t2_addr_after_pop", last_fire_addr, 64'h1010);

    // Redirect with two responses in flight.
    do_reset();
    lat_lo = 6; lat_hi = 6;
    repeat (2) step(0, 0, 1, 1);
    step(1, 64'h2003, 1, 1);
    track_first = 1;
    step(0, 0, 1, 1); chk("t3_addr", s_req_addr, 64'h2000);
    repeat (15) step(0, 0, 1, 1);
    chk("t3_first_pc", first_pc, 64'h2000);

    // PC wrap at the top of the address space.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    step(0, 0, 1, 1); chk("t4_addr_top", s_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 1, 1); chk("t4_addr_wrap", s_req_addr, 64'h0);
    repeat (6) step(0, 0, 1, 1);

    // Redirect coinciding with a response while the consumer is ready.
    do_reset();
    lat_lo = 2; lat_hi = 2;
    repeat (4) step(0, 0, 0, 1);
    step(1, 64'h3000, 1, 1);
    chk("t5_redir_inst_valid", s_inst_valid, 0);
    step(0, 0, 0, 0);
    chk("t5_empty", s_inst_valid, 0);
    track_first = 1;
    repeat (10) step(0, 0, 1, 1);
    chk("t5_first_pc", first_pc, 64'h3000);

    // Response-to-output latency at an empty queue.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(0, 0, 1, 1);
    step(0, 0, 1, 1); chk("t6_same_cycle_valid", s_inst_valid, BYP);
    step(0, 0, 1, 1); chk("t6_next_cycle_valid", s_inst_valid, 1);

    // Randomized traffic with a mid-run reset.
    do_reset();
    lat_lo = 1; lat_hi = 4; rsp_pct = 75;
    for (int n = 0; n < 1500; n++) begin
      logic [63:0] rpc;
      bit          rd;
      if (n == 750) do_reset();
      rd  = ($urandom_range(0, 29) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom)}
                                        : {32'h0, $urandom};
      step(rd, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
